// File: rtl/ase_pcie_ss_tx_pkt_buffer.sv
// Store-and-forward TLP buffer on the AFU->host TX AXI-S path.
// A beat is offered downstream only once its whole packet (through tlast) is
// held, except in the deadlock-guard cut-through mode used for oversize TLPs.
module ase_pcie_ss_tx_pkt_buffer #(
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TUSER_WIDTH = 10,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned MAX_PKTS    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_tvalid,
    output logic                         in_tready,
    input  logic [TDATA_WIDTH-1:0]       in_tdata,
    input  logic [TUSER_WIDTH-1:0]       in_tuser,
    input  logic [TDATA_WIDTH/8-1:0]     in_tkeep,
    input  logic                         in_tlast,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic [TDATA_WIDTH-1:0]       out_tdata,
    output logic [TUSER_WIDTH-1:0]       out_tuser,
    output logic [TDATA_WIDTH/8-1:0]     out_tkeep,
    output logic                         out_tlast,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic [$clog2(MAX_PKTS):0]    pkt_count,
    output logic                         err_oversize
);

    localparam int unsigned KEEP_W  = TDATA_WIDTH / 8;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam int unsigned PKT_W   = $clog2(MAX_PKTS) + 1;
    localparam int unsigned ENTRY_W = TDATA_WIDTH + TUSER_WIDTH + KEEP_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CUT  = 1'b1
    } state_e;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic [PKT_W-1:0] pkt_count_q, pkt_count_d;
    state_e           state_q, state_d;
    logic             err_q, err_d;
    logic             rst_n_q;
    logic             in_acc;
    logic             out_acc;

    // One-cycle registered reset release gates the input side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_n_q <= 1'b0;
        else        rst_n_q <= 1'b1;
    end

    // Beat storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (in_acc) mem_q[wr_ptr_q] <= {in_tdata, in_tuser, in_tkeep, in_tlast};
    end

    // Handshakes and first-word-fall-through head presentation
    always_comb begin
        head       = mem_q[rd_ptr_q];
        in_tready  = rst_n_q && (occupancy_q < OCC_W'(DEPTH)) && (pkt_count_q < PKT_W'(MAX_PKTS));
        out_tvalid = (occupancy_q != '0) && ((pkt_count_q != '0) || (state_q == ST_CUT));
        out_tdata  = '0;
        out_tuser  = '0;
        out_tkeep  = '0;
        out_tlast  = 1'b0;
        if (out_tvalid) begin
            {out_tdata, out_tuser, out_tkeep, out_tlast} = head;
        end
        in_acc       = in_tvalid && in_tready && !flush;
        out_acc      = out_tvalid && out_tready && !flush;
        occupancy    = occupancy_q;
        pkt_count    = pkt_count_q;
        err_oversize = err_q;
    end

    // Next-state: pointers, counters and the cut-through deadlock guard
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occupancy_d = occupancy_q;
        pkt_count_d = pkt_count_q;
        state_d     = state_q;
        err_d       = err_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occupancy_d = '0;
            pkt_count_d = '0;
            state_d     = ST_IDLE;
            err_d       = 1'b0;
        end else begin
            if (in_acc)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (out_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);

            if (in_acc && !out_acc)      occupancy_d = occupancy_q + OCC_W'(1);
            else if (!in_acc && out_acc) occupancy_d = occupancy_q - OCC_W'(1);

            pkt_count_d = pkt_count_q + PKT_W'(in_acc && in_tlast)
                                      - PKT_W'(out_acc && out_tlast);

            case (state_q)
                ST_IDLE: begin
                    // Full of a single unterminated packet: stream it out
                    if ((occupancy_q == OCC_W'(DEPTH)) && (pkt_count_q == '0)) begin
                        state_d = ST_CUT;
                        err_d   = 1'b1;
                    end
                end
                ST_CUT: begin
                    if (out_acc && out_tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
            pkt_count_q <= '0;
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occupancy_q <= occupancy_d;
            pkt_count_q <= pkt_count_d;
            state_q     <= state_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ase_pcie_ss_tx_pkt_buffer.sv
// Randomized bench for the TX packet buffer against a queue-based reference model.
module tb_ase_pcie_ss_tx_pkt_buffer;

    localparam int unsigned TDW   = 512;
    localparam int unsigned TUW   = 10;
    localparam int unsigned KW    = TDW / 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned MAXP  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_tvalid = 1'b0;
    logic           in_tready;
    logic [TDW-1:0] in_tdata = '0;
    logic [TUW-1:0] in_tuser = '0;
    logic [KW-1:0]  in_tkeep = '0;
    logic           in_tlast = 1'b0;
    logic           out_tvalid;
    logic           out_tready = 1'b0;
    logic [TDW-1:0] out_tdata;
    logic [TUW-1:0] out_tuser;
    logic [KW-1:0]  out_tkeep;
    logic           out_tlast;
    logic [6:0]     occupancy;
    logic [4:0]     pkt_count;
    logic           err_oversize;

    ase_pcie_ss_tx_pkt_buffer #(
        .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .DEPTH(DEPTH), .MAX_PKTS(MAXP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tuser(in_tuser), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tuser(out_tuser), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .occupancy(occupancy), .pkt_count(pkt_count), .err_oversize(err_oversize)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TDW-1:0] data;
        logic [TUW-1:0] user;
        logic [KW-1:0]  keep;
        logic           last;
    } beat_t;

    beat_t src[$];   // beats the AFU still has to send
    beat_t mq[$];    // beats the buffer should be holding, oldest first
    bit    m_cut;
    bit    m_err;
    bit    m_rstq;
    int    n_vec;
    int    n_bad;

    task automatic chk(input string tag, input logic [599:0] act, input logic [599:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int m_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i].last) n++;
        return n;
    endfunction

    function automatic bit pred_tready();
        return m_rstq && (mq.size() < DEPTH) && (m_pkts() < MAXP);
    endfunction

    function automatic bit pred_tvalid();
        return (mq.size() > 0) && ((m_pkts() > 0) || m_cut);
    endfunction

    task automatic add_pkt(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < TDW / 32; w++) b.data[w*32 +: 32] = $urandom;
            b.user = TUW'($urandom);
            b.keep = {$urandom, $urandom};
            b.last = (i == len - 1);
            src.push_back(b);
        end
    endtask

    // One clock: check at negedge, drive, update the model at posedge
    task automatic cycle(input bit f, input bit iv_req, input bit ordy);
        bit    pr, pv, ia, oa, iv;
        beat_t b;
        pr = pred_tready();
        pv = pred_tvalid();
        chk("in_tready", in_tready, pr);
        chk("out_tvalid", out_tvalid, pv);
        chk("occupancy", occupancy, mq.size());
        chk("pkt_count", pkt_count, m_pkts());
        chk("err_oversize", err_oversize, m_err);
        if (pv) begin
            chk("out_tdata", out_tdata, mq[0].data);
            chk("out_tuser", out_tuser, mq[0].user);
            chk("out_tkeep", out_tkeep, mq[0].keep);
            chk("out_tlast", out_tlast, mq[0].last);
        end
        iv = iv_req && (src.size() > 0);
        b  = (src.size() > 0) ? src[0] : '0;
        flush      = f;
        in_tvalid  = iv;
        {in_tdata, in_tuser, in_tkeep, in_tlast} = b;
        out_tready = ordy;
        @(posedge clk);
        if (f) begin
            mq.delete();
            m_cut = 1'b0;
            m_err = 1'b0;
        end else begin
            ia = iv && pr;
            oa = pv && ordy;
            if (!m_cut && (mq.size() == DEPTH) && (m_pkts() == 0)) begin
                m_cut = 1'b1;
                m_err = 1'b1;
            end else if (m_cut && oa && mq[0].last) begin
                m_cut = 1'b0;
            end
            if (oa) void'(mq.pop_front());
            if (ia) mq.push_back(src.pop_front());
        end
        m_rstq = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int in_pct, input int out_pct);
        for (int i = 0; i < n; i++)
            cycle(1'b0, $urandom_range(99) < in_pct, $urandom_range(99) < out_pct);
    endtask

    initial begin
        int total;
        int guard;
        n_vec  = 0;
        n_bad  = 0;
        m_cut  = 1'b0;
        m_err  = 1'b0;
        m_rstq = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_tready", in_tready, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_err", err_oversize, 0);
        chk("rst_out_tdata", out_tdata, 0);
        chk("rst_out_tlast", out_tlast, 0);
        rst_n = 1'b1;

        // Single 3-beat TLP, sink always ready
        add_pkt(3);
        run(10, 100, 100);

        // 17 one-beat TLPs into a stalled sink: packet limit stops intake at 16
        for (int i = 0; i < 17; i++) add_pkt(1);
        run(25, 100, 0);
        chk("fill_occupancy", occupancy, 16);
        chk("fill_in_tready", in_tready, 0);
        run(40, 100, 100);

        // 70-beat TLP: buffer fills without a tlast, cut-through engages
        add_pkt(70);
        run(80, 100, 0);
        chk("oversize_err", err_oversize, 1);
        chk("oversize_occupancy", occupancy, DEPTH);
        run(100, 100, 100);
        chk("oversize_err_sticky", err_oversize, 1);
        chk("oversize_drained", occupancy, 0);

        // Simultaneous tlast in and tlast out with one packet held
        add_pkt(1);
        run(3, 100, 0);
        add_pkt(1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("simul_pkt_count", pkt_count, 1);
        chk("simul_occupancy", occupancy, 1);
        run(5, 0, 100);

        // Flush with 5 beats of a partial packet stored
        add_pkt(8);
        run(5, 100, 0);
        cycle(1'b1, 1'b1, 1'b1);
        src.delete();
        chk("flush_occupancy", occupancy, 0);
        chk("flush_pkt_count", pkt_count, 0);
        chk("flush_out_tvalid", out_tvalid, 0);
        add_pkt(2);
        run(10, 100, 100);

        // Random streaming of 1..8-beat TLPs with a 50% ready sink
        total = 0;
        while (total < 10000) begin
            int l;
            l = int'($urandom_range(8, 1));
            add_pkt(l);
            total += l;
        end
        guard = 0;
        while ((src.size() > 0 || mq.size() > 0) && guard < 60000) begin
            cycle(1'b0, $urandom_range(99) < 70, $urandom_range(99) < 50);
            guard++;
        end
        chk("stream_drained", src.size() + mq.size(), 0);
        run(3, 0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
